lifting_mac_unit: RTL and testbench

//  Fixed-point multiply-accumulate element for the recursive DAUB-4 lifting DWT datapath.

---
 rtl/lifting_mac_unit_if.sv | 22 ++
 rtl/lifting_mac_unit.sv | 69 ++++++
 tb/tb_lifting_mac_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/lifting_mac_unit_if.sv
// Operand/result bundle for one lifting MAC element; the lifting datapath drives
// the master side, the MAC element is the slave.
interface lifting_mac_unit_if #(
    parameter int WIDTH = 32
);
    logic             mult_only;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in3;
    logic [WIDTH-1:0] cons;
    logic [WIDTH-1:0] d;

    modport master (
        output mult_only, in0, in1, in3, cons,
        input  d
    );

    modport slave (
        input  mult_only, in0, in1, in3, cons,
        output d
    );
endinterface

// File: rtl/lifting_mac_unit.sv
// DAUB-4 lifting MAC: d = in3 + (cons*(in0+in1)) >>> FRAC, or (cons*in0) >>> FRAC in
// multiply-only mode. Optional output clamping with `define SATURATE_EN (default: wrap).
module lifting_mac_unit #(
    parameter int WIDTH   = 32,
    parameter int FRAC    = 16,
    parameter int OUT_REG = 1
) (
    input logic              clk,
    input logic              reset,
    lifting_mac_unit_if.slave mac
);
    localparam int AW = 2 * WIDTH + 1;

    logic signed [WIDTH:0]  sum;
    logic signed [AW-1:0]   sum_ext;
    logic signed [AW-1:0]   cons_ext;
    logic signed [AW-1:0]   in3_ext;
    logic signed [AW-1:0]   prod;
    logic signed [AW-1:0]   scaled;
    logic signed [AW-1:0]   acc;
    logic [WIDTH-1:0]       d_d;

    // Everything is carried at 2*WIDTH+1 bits so the product and accumulate are exact
    // before narrowing; the arithmetic shift gives floor toward -inf.
    always_comb begin
        sum      = mac.mult_only ? {mac.in0[WIDTH-1], mac.in0}
                                 : ({mac.in0[WIDTH-1], mac.in0} + {mac.in1[WIDTH-1], mac.in1});
        sum_ext  = {{WIDTH{sum[WIDTH]}}, sum};
        cons_ext = {{(WIDTH+1){mac.cons[WIDTH-1]}}, mac.cons};
        in3_ext  = mac.mult_only ? '0 : {{(WIDTH+1){mac.in3[WIDTH-1]}}, mac.in3};
        prod     = sum_ext * cons_ext;
        scaled   = prod >>> FRAC;
        acc      = scaled + in3_ext;
`ifdef SATURATE_EN
        if ((&acc[AW-1:WIDTH-1]) || !(|acc[AW-1:WIDTH-1])) begin
            d_d = acc[WIDTH-1:0];
        end else if (acc[AW-1]) begin
            d_d = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            d_d = {1'b0, {(WIDTH-1){1'b1}}};
        end
`else
        d_d = acc[WIDTH-1:0];
`endif
    end

`ifndef SATURATE_EN
    logic unused_acc_hi;
    assign unused_acc_hi = ^acc[AW-1:WIDTH];
`endif

    if (OUT_REG != 0) begin : g_reg
        logic [WIDTH-1:0] d_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                d_q <= '0;
            end else begin
                d_q <= d_d;
            end
        end

        assign mac.d = d_q;
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ reset;
        assign mac.d          = d_d;
    end
endmodule

// File: tb/tb_lifting_mac_unit.sv
// Scoreboard bench for lifting_mac_unit: registered and combinational instances side by side.
module tb_lifting_mac_unit;
    logic clk = 1'b0;
    logic rst;
    logic issue;
    logic vld_r;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] q_reg[$];
    logic [31:0] q_comb[$];

    lifting_mac_unit_if #(.WIDTH(32)) ifr ();
    lifting_mac_unit_if #(.WIDTH(32)) ifc ();

    lifting_mac_unit #(.WIDTH(32), .FRAC(16), .OUT_REG(1)) u_reg (
        .clk(clk), .reset(rst), .mac(ifr)
    );
    lifting_mac_unit #(.WIDTH(32), .FRAC(16), .OUT_REG(0)) u_comb (
        .clk(clk), .reset(rst), .mac(ifc)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] ALPHA  = 32'hFFFE4498;
    localparam logic [31:0] LAMBDA = 32'h00010000;
    localparam logic [31:0] OMEGA  = 32'h0001EE8E;

    // Reference: exact integer arithmetic, floor division by 2^16.
    function automatic logic [31:0] ref_mac(input logic mo, input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c3, input logic [31:0] k);
        logic signed [127:0] s, p, q;
        s = $signed(a);
        if (!mo) s = s + $signed(b);
        p = s * $signed(k);
        q = p / 65536;
        if (p < 0 && (p % 65536) != 0) q = q - 1;
        if (!mo) q = q + $signed(c3);
`ifdef SATURATE_EN
        if (q > 128'sd2147483647) return 32'h7FFFFFFF;
        if (q < -128'sd2147483648) return 32'h80000000;
`endif
        return q[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) vld_r <= issue && !rst;

    // Monitor: comb result of the vector currently applied; registered result of last cycle's.
    always @(negedge clk) begin
        if (issue) begin
            if (q_comb.size() == 0) begin
                checks++; errors++;
                $display("FAIL comb_underflow got output expected nothing at %0t", $time);
            end else check("comb_d", ifc.d, q_comb.pop_front());
        end
        if (vld_r && !rst) begin
            if (q_reg.size() == 0) begin
                checks++; errors++;
                $display("FAIL reg_underflow got output expected nothing at %0t", $time);
            end else check("reg_d", ifr.d, q_reg.pop_front());
        end
    end

    task automatic drive(input logic mo, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c3, input logic [31:0] k);
        ifr.mult_only = mo; ifr.in0 = a; ifr.in1 = b; ifr.in3 = c3; ifr.cons = k;
        ifc.mult_only = mo; ifc.in0 = a; ifc.in1 = b; ifc.in3 = c3; ifc.cons = k;
    endtask

    task automatic issue_vec(input logic mo, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c3, input logic [31:0] k, input logic [31:0] e);
        @(posedge clk);
        #1;
        drive(mo, a, b, c3, k);
        issue = 1'b1;
        q_comb.push_back(e);
        q_reg.push_back(e);
    endtask

    task automatic issue_rand();
        logic        mo;
        logic [31:0] a, b, c3, k;
        mo = ($urandom_range(0, 3) == 0);
        a  = $urandom; b = $urandom; c3 = $urandom; k = $urandom;
        if ($urandom_range(0, 1) == 1) begin
            a  = 32'($signed(a) >>> 12);
            b  = 32'($signed(b) >>> 12);
            k  = 32'($signed(k) >>> 12);
            c3 = 32'($signed(c3) >>> 8);
        end
        issue_vec(mo, a, b, c3, k, ref_mac(mo, a, b, c3, k));
    endtask

    task automatic mid_reset();
        issue_rand();
        #2;
        rst = 1'b1;
        q_reg.delete();
        #1;
        check("midreset_d", ifr.d, 32'h0);
        issue_rand();
        #2;
        rst = 1'b0;
    endtask

    typedef struct {
        logic        mo;
        logic [31:0] a, b, c3, k, e;
    } vec_t;

    vec_t dir[$];

    initial begin
        rst = 1'b1;
        issue = 1'b0;
        drive(1'b0, 32'h12345678, 32'h0BADBEEF, 32'h55555555, 32'h00030000);
        #2;
        check("reset_d", ifr.d, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        check("reset_edge_d", ifr.d, 32'h0);
        #1;
        rst = 1'b0;
        #1;
        check("release_hold_d", ifr.d, 32'h0);

        dir.push_back('{1'b0, 32'h00010000, 32'h0,        32'h00020000, LAMBDA,       32'h00030000});
        dir.push_back('{1'b0, 32'h00010000, 32'h0,        32'h0,        ALPHA,        32'hFFFE4498});
        dir.push_back('{1'b0, 32'hFFFF0000, 32'h0,        32'h0,        ALPHA,        32'h0001BB68});
        dir.push_back('{1'b1, 32'h00020000, 32'hDEADBEEF, 32'h12345678, OMEGA,        32'h0003DD1C});
        dir.push_back('{1'b0, 32'h00000001, 32'h0,        32'h0,        32'h00008000, 32'h00000000});
        dir.push_back('{1'b0, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h00008000, 32'hFFFFFFFF});
`ifdef SATURATE_EN
        dir.push_back('{1'b0, 32'h00010000, 32'h0,        32'h7FFF0000, LAMBDA,       32'h7FFFFFFF});
`else
        dir.push_back('{1'b0, 32'h00010000, 32'h0,        32'h7FFF0000, LAMBDA,       32'h80000000});
`endif
        foreach (dir[i]) issue_vec(dir[i].mo, dir[i].a, dir[i].b, dir[i].c3, dir[i].k, dir[i].e);

        for (int i = 0; i < 200; i++) begin
            if (i == 60 || i == 140) mid_reset();
            else issue_rand();
        end

        @(posedge clk);
        #1;
        issue = 1'b0;
        for (int n = 0; n < 10 && (q_reg.size() != 0 || q_comb.size() != 0); n++) @(posedge clk);
        if (q_reg.size() != 0 || q_comb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain got %0d pending expected 0", q_reg.size() + q_comb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
